mem_lsu: RTL and testbench

Load/store unit for the memory stage of the simple_cpu pipeline. Takes one memory operation from EX/MEM, runs a request/grant/response handshake with the data memory, formats load data (byte/half extraction, sign/zero extension) and presents `load_rdata` to `wb_mux` with a stall to hold the pipeline while the access is outstanding. Also generates store byte enables and lane-replicated write data, and flags misaligned accesses without touching memory.

---
 rtl/mem_lsu_if.sv | 51 +++++
 rtl/mem_lsu.sv | 210 +++++++++++++++++++++
 tb/tb_mem_lsu.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_if.sv
// ---------------------------------------------------------------------------
// mem_lsu_if
//   Data-memory bus between the load/store unit and the data memory.
//   One request is outstanding at a time: the master holds dmem_req and its
//   fields stable until dmem_gnt. Loads are answered later by dmem_rvalid
//   with dmem_rdata.
//
//   Signals
//     dmem_req    master->slave  request
//     dmem_we     master->slave  1 = write
//     dmem_addr   master->slave  word-aligned byte address
//     dmem_be     master->slave  byte enables
//     dmem_wdata  master->slave  lane-replicated store data
//     dmem_gnt    slave->master  request accepted this cycle
//     dmem_rvalid slave->master  read data valid
//     dmem_rdata  slave->master  read word
// ---------------------------------------------------------------------------
interface mem_lsu_if #(
    parameter int DATA_WIDTH = 32
);
    logic                    dmem_req;
    logic                    dmem_we;
    logic [DATA_WIDTH-1:0]   dmem_addr;
    logic [DATA_WIDTH/8-1:0] dmem_be;
    logic [DATA_WIDTH-1:0]   dmem_wdata;
    logic                    dmem_gnt;
    logic                    dmem_rvalid;
    logic [DATA_WIDTH-1:0]   dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_be,
        output dmem_wdata,
        input  dmem_gnt,
        input  dmem_rvalid,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_be,
        input  dmem_wdata,
        output dmem_gnt,
        output dmem_rvalid,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_lsu.sv
// ---------------------------------------------------------------------------
// mem_lsu
//   Memory-stage load/store unit. Accepts one memory operation from EX/MEM,
//   runs the request/grant/response handshake on the data-memory bus, formats
//   load data (byte/half extraction with sign/zero extension) and stalls the
//   pipeline while the access is outstanding. Stores get byte enables and
//   lane-replicated write data. Misaligned accesses are flagged and never
//   reach memory.
//
//   Ports
//     clk            in   clock, rising edge
//     rst_n          in   asynchronous active-low reset
//     i_op_valid     in   EX/MEM holds a valid instruction (stable until done)
//     i_is_load      in   operation is a load
//     i_is_store     in   operation is a store
//     i_funct3       in   size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//     i_addr         in   effective byte address
//     i_store_data   in   rs2 value
//     i_kill         in   flush the current operation
//     dmem           ---  data-memory bus (mem_lsu_if.master)
//     o_stall        out  hold the pipeline
//     o_resp_valid   out  one-cycle completion pulse
//     o_load_rdata   out  formatted load result
//     o_misaligned   out  combinational alignment fault on the current op
// ---------------------------------------------------------------------------
module mem_lsu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_op_valid,
    input  logic                  i_is_load,
    input  logic                  i_is_store,
    input  logic [2:0]            i_funct3,
    input  logic [DATA_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_store_data,
    input  logic                  i_kill,
    mem_lsu_if.master             dmem,
    output logic                  o_stall,
    output logic                  o_resp_valid,
    output logic [DATA_WIDTH-1:0] o_load_rdata,
    output logic                  o_misaligned
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  r_state;
    logic                    r_req;
    logic                    r_we;
    logic [DATA_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH/8-1:0] r_be;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [2:0]              r_funct3;
    logic [1:0]              r_off;
    logic [DATA_WIDTH-1:0]   r_load_rdata;
    logic                    r_resp_valid;

    logic                    w_mem_op;
    logic                    w_misal;
    logic                    w_launch;

    // Access size comes from funct3[1:0]; the encoding 11 (funct3 011/111)
    // and 110 fall into the word case, so they are checked and formatted as W.
    function automatic logic misal_f(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            default: return (off != 2'b00);
        endcase
    endfunction

    function automatic logic [DATA_WIDTH/8-1:0] store_be_f(input logic [2:0] f3,
                                                         input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] store_wdata_f(input logic [2:0] f3,
                                                          input logic [DATA_WIDTH-1:0] sd);
        case (f3[1:0])
            2'b00:   return {4{sd[7:0]}};
            2'b01:   return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] load_fmt_f(input logic [2:0] f3,
                                                       input logic [1:0] off,
                                                       input logic [DATA_WIDTH-1:0] rd);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = rd[8*off +: 8];
        h = rd[16*off[1] +: 16];
        case (f3)
            3'b000:  return DATA_WIDTH'(b);
            3'b001:  return DATA_WIDTH'(h);
            3'b100:  return DATA_WIDTH'($unsigned(b));
            3'b101:  return DATA_WIDTH'($unsigned(h));
            default: return rd;
        endcase
    endfunction

    assign w_mem_op     = i_is_load | i_is_store;
    assign w_misal      = misal_f(i_funct3, i_addr[1:0]);
    assign o_misaligned = i_op_valid & w_mem_op & w_misal;
    assign w_launch     = (r_state == S_IDLE) & i_op_valid & w_mem_op & ~w_misal & ~i_kill;

    always_comb begin
        o_stall = w_launch;
        if ((r_state == S_REQ) || (r_state == S_WAIT) || (r_state == S_DRAIN)) begin
            o_stall = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_funct3     <= 3'b000;
            r_off        <= 2'b00;
            r_load_rdata <= '0;
            r_resp_valid <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A late rvalid from an abandoned access lands here and is ignored.
                    if (w_launch) begin
                        r_state  <= S_REQ;
                        r_req    <= 1'b1;
                        r_we     <= i_is_store;
                        r_addr   <= {i_addr[DATA_WIDTH-1:2], 2'b00};
                        r_be     <= i_is_store ? store_be_f(i_funct3, i_addr[1:0]) : '0;
                        r_wdata  <= i_is_store ? store_wdata_f(i_funct3, i_store_data) : '0;
                        r_funct3 <= i_funct3;
                        r_off    <= i_addr[1:0];
                    end
                end
                S_REQ: begin
                    if (dmem.dmem_gnt) begin
                        r_req <= 1'b0;
                        if (r_we) begin
                            // A killed store that was granted has already been
                            // written; it just completes silently.
                            if (i_kill) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_state      <= S_DONE;
                                r_resp_valid <= 1'b1;
                            end
                        end else begin
                            // A granted load owes us a response; a kill must
                            // still swallow it.
                            r_state <= i_kill ? S_DRAIN : S_WAIT;
                        end
                    end else if (i_kill) begin
                        r_req   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (i_kill) begin
                        // rvalid in the kill cycle is the response we would
                        // otherwise drain, so drop it and return to IDLE.
                        r_state <= dmem.dmem_rvalid ? S_IDLE : S_DRAIN;
                    end else if (dmem.dmem_rvalid) begin
                        r_load_rdata <= load_fmt_f(r_funct3, r_off, dmem.dmem_rdata);
                        r_state      <= S_DONE;
                        r_resp_valid <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (dmem.dmem_rvalid) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_be    = r_be;
    assign dmem.dmem_wdata = r_wdata;

    assign o_resp_valid = r_resp_valid;
    assign o_load_rdata = r_load_rdata;

endmodule

// File: tb/tb_mem_lsu.sv
// ---------------------------------------------------------------------------
// tb_mem_lsu
//   Directed bench for mem_lsu. Inputs are driven 1 ns after the rising edge
//   and outputs sampled 1 ns later; the memory side is driven by hand per
//   cycle with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_mem_lsu;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        kill;
    logic        stall;
    logic        resp_valid;
    logic [31:0] load_rdata;
    logic        misaligned;

    int n_checks = 0;
    int n_fail   = 0;

    mem_lsu_if #(.DATA_WIDTH(32)) m ();

    mem_lsu #(.DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_op_valid   (op_valid),
        .i_is_load    (is_load),
        .i_is_store   (is_store),
        .i_funct3     (funct3),
        .i_addr       (addr),
        .i_store_data (store_data),
        .i_kill       (kill),
        .dmem         (m),
        .o_stall      (stall),
        .o_resp_valid (resp_valid),
        .o_load_rdata (load_rdata),
        .o_misaligned (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd);
        op_valid   = 1'b1;
        is_load    = ld;
        is_store   = st;
        funct3     = f3;
        addr       = a;
        store_data = sd;
    endtask

    task automatic clr_op();
        op_valid = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        kill     = 1'b0;
    endtask

    // Zero-wait load: launch, REQ+gnt, WAIT+rvalid, DONE.
    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] rd, input logic [31:0] exp);
        set_op(1'b1, 1'b0, f3, a, 32'h0);
        #1;
        chk({tag, "_launch_stall"}, stall, 1);
        chk({tag, "_launch_misal"}, misaligned, 0);
        chk({tag, "_launch_req"}, m.dmem_req, 0);
        cyc();
        chk({tag, "_req"}, m.dmem_req, 1);
        chk({tag, "_addr"}, m.dmem_addr, {a[31:2], 2'b00});
        chk({tag, "_be"}, m.dmem_be, 0);
        chk({tag, "_we"}, m.dmem_we, 0);
        m.dmem_gnt = 1'b1;
        cyc();
        m.dmem_gnt   = 1'b0;
        m.dmem_rvalid = 1'b1;
        m.dmem_rdata  = rd;
        #1;
        chk({tag, "_wait_req"}, m.dmem_req, 0);
        chk({tag, "_wait_stall"}, stall, 1);
        chk({tag, "_wait_resp"}, resp_valid, 0);
        cyc();
        m.dmem_rvalid = 1'b0;
        #1;
        chk({tag, "_done_resp"}, resp_valid, 1);
        chk({tag, "_done_data"}, load_rdata, exp);
        chk({tag, "_done_stall"}, stall, 0);
        cyc();
        clr_op();
        #1;
        chk({tag, "_idle_resp"}, resp_valid, 0);
    endtask

    // Zero-wait store: launch, REQ+gnt, DONE.
    task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] sd, input logic [3:0] exp_be,
                             input logic [31:0] exp_wd, input logic [31:0] hold_rdata);
        set_op(1'b0, 1'b1, f3, a, sd);
        #1;
        chk({tag, "_launch_stall"}, stall, 1);
        chk({tag, "_launch_misal"}, misaligned, 0);
        cyc();
        chk({tag, "_req"}, m.dmem_req, 1);
        chk({tag, "_addr"}, m.dmem_addr, {a[31:2], 2'b00});
        chk({tag, "_be"}, m.dmem_be, exp_be);
        chk({tag, "_wdata"}, m.dmem_wdata, exp_wd);
        chk({tag, "_we"}, m.dmem_we, 1);
        m.dmem_gnt = 1'b1;
        cyc();
        m.dmem_gnt = 1'b0;
        #1;
        chk({tag, "_done_resp"}, resp_valid, 1);
        chk({tag, "_done_req"}, m.dmem_req, 0);
        chk({tag, "_done_stall"}, stall, 0);
        chk({tag, "_rdata_hold"}, load_rdata, hold_rdata);
        cyc();
        clr_op();
        #1;
        chk({tag, "_idle_resp"}, resp_valid, 0);
    endtask

    initial begin
        int n_req;
        int n_stall;
        int n_resp;

        rst_n         = 1'b0;
        op_valid      = 1'b0;
        is_load       = 1'b0;
        is_store      = 1'b0;
        funct3        = 3'b000;
        addr          = 32'h0;
        store_data    = 32'h0;
        kill          = 1'b0;
        m.dmem_gnt    = 1'b0;
        m.dmem_rvalid = 1'b0;
        m.dmem_rdata  = 32'h0;

        cyc();
        cyc();
        chk("rst_req", m.dmem_req, 0);
        chk("rst_we", m.dmem_we, 0);
        chk("rst_addr", m.dmem_addr, 0);
        chk("rst_be", m.dmem_be, 0);
        chk("rst_wdata", m.dmem_wdata, 0);
        chk("rst_resp", resp_valid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_rdata", load_rdata, 0);
        rst_n = 1'b1;
        cyc();

        // Byte loads from the top lane: 0x80 sign- and zero-extended.
        run_load("lb", 3'b000, 32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80);
        run_load("lbu", 3'b100, 32'h0000_1003, 32'h80FF_1234, 32'h0000_0080);

        run_store("sh", 3'b001, 32'h0000_2002, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF,
                  32'h0000_0080);
        run_load("lw", 3'b010, 32'h0000_3000, 32'h1234_5678, 32'h1234_5678);
        run_load("lh_hi", 3'b001, 32'h0000_3002, 32'h8001_0000, 32'hFFFF_8001);
        run_load("lhu_lo", 3'b101, 32'h0000_3000, 32'h1234_F00D, 32'h0000_F00D);
        run_load("lw_f3_111", 3'b111, 32'h0000_3004, 32'hA5A5_0101, 32'hA5A5_0101);

        // Misaligned word load: flagged, never requested, never stalls.
        set_op(1'b1, 1'b0, 3'b010, 32'h0000_0001, 32'h0);
        #1;
        chk("mis_flag", misaligned, 1);
        chk("mis_stall", stall, 0);
        n_req = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (m.dmem_req) n_req++;
            if (stall) n_req++;
        end
        chk("mis_no_req_stall", n_req, 0);
        clr_op();
        cyc();

        run_store("sb", 3'b000, 32'h0000_0003, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5,
                  32'hA5A5_0101);

        // Grant withheld 3 cycles, rvalid 2 cycles after gnt.
        set_op(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0);
        n_req   = 0;
        n_stall = 0;
        n_resp  = 0;
        for (int c = 0; c < 10; c++) begin
            m.dmem_gnt    = (c == 4);
            m.dmem_rvalid = (c == 6);
            m.dmem_rdata  = (c == 6) ? 32'hCAFE_F00D : 32'h0;
            if (c == 8) clr_op();
            #1;
            if (m.dmem_req) begin
                n_req++;
                chk("ws_addr_stable", m.dmem_addr, 32'h0000_4000);
            end
            if (stall) n_stall++;
            if (resp_valid) n_resp++;
            cyc();
        end
        m.dmem_gnt    = 1'b0;
        m.dmem_rvalid = 1'b0;
        chk("ws_req_cycles", n_req, 4);
        chk("ws_stall_cycles", n_stall, 7);
        chk("ws_resp_count", n_resp, 1);
        chk("ws_data", load_rdata, 32'hCAFE_F00D);

        // Kill in WAIT: drained response is dropped.
        set_op(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0);
        n_resp = 0;
        cyc();
        m.dmem_gnt = 1'b1;
        cyc();
        m.dmem_gnt = 1'b0;
        kill = 1'b1;
        #1;
        chk("kw_wait_stall", stall, 1);
        if (resp_valid) n_resp++;
        cyc();
        clr_op();
        #1;
        chk("kw_drain_stall", stall, 1);
        if (resp_valid) n_resp++;
        cyc();
        m.dmem_rvalid = 1'b1;
        m.dmem_rdata  = 32'hDEAD_BEEF;
        #1;
        chk("kw_drain_stall2", stall, 1);
        if (resp_valid) n_resp++;
        cyc();
        m.dmem_rvalid = 1'b0;
        #1;
        chk("kw_idle_stall", stall, 0);
        if (resp_valid) n_resp++;
        cyc();
        if (resp_valid) n_resp++;
        chk("kw_no_resp", n_resp, 0);
        chk("kw_rdata_kept", load_rdata, 32'hCAFE_F00D);

        // Kill in REQ without gnt: back to IDLE, request withdrawn.
        set_op(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'h0);
        cyc();
        chk("kr_req", m.dmem_req, 1);
        kill = 1'b1;
        cyc();
        clr_op();
        #1;
        chk("kr_req_drop", m.dmem_req, 0);
        chk("kr_stall", stall, 0);
        chk("kr_resp", resp_valid, 0);
        cyc();

        // Reset in WAIT: abandon the access, ignore the stray rvalid.
        set_op(1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0);
        cyc();
        m.dmem_gnt = 1'b1;
        cyc();
        m.dmem_gnt = 1'b0;
        clr_op();
        rst_n = 1'b0;
        #1;
        chk("rw_req", m.dmem_req, 0);
        chk("rw_addr", m.dmem_addr, 0);
        chk("rw_stall", stall, 0);
        chk("rw_rdata", load_rdata, 0);
        cyc();
        rst_n = 1'b1;
        m.dmem_rvalid = 1'b1;
        m.dmem_rdata  = 32'h5555_AAAA;
        cyc();
        m.dmem_rvalid = 1'b0;
        #1;
        chk("rw_stray_resp", resp_valid, 0);
        chk("rw_stray_stall", stall, 0);
        cyc();
        chk("rw_stray_resp2", resp_valid, 0);
        chk("rw_stray_rdata", load_rdata, 0);

        run_load("rw_lw", 3'b010, 32'h0000_8000, 32'h0BAD_F00D, 32'h0BAD_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
